lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter PASSWORD, default 16'h1234, the 4-digit BCD code; nibble [15:12] is entered first.
REQ-002 SHALL have parameter OPEN_CYCLES, default 32'd149_999_999, the unlock hold time (3 s at 50 MHz).
REQ-003 SHALL have parameter LOCK_CYCLES, default 32'd499_999_999, the lockout time (10 s).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd499_999_999, the entry inactivity timeout.
REQ-005 SHALL have parameter MAX_FAIL, default 2'd3, the consecutive failures before lockout.
REQ-006 SHALL have port clk, input, 1 bit: the clock.
REQ-007 SHALL have port rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-008 SHALL have ports key_inc, key_next, key_ok and key_clr, each input, 1 bit: single-cycle pulses from the debounced key filters.
REQ-009 SHALL have port unlock, output, 1 bit: drives the lock actuator.
REQ-010 SHALL have port alarm, output, 1 bit: high during lockout.
REQ-011 SHALL have port err_pulse, output, 1 bit: a 1-cycle pulse on each wrong code.
REQ-012 SHALL have port pos, output, 2 bits: index of the digit being entered.
REQ-013 SHALL have port digit, output, 4 bits: the current digit value, for display.
REQ-014 SHALL have port fail_cnt, output, 2 bits: consecutive failures so far.
REQ-015 SHALL have port state, output, 2 bits: ENTRY=0, CHECK=1, OPEN=2, LOCKOUT=3.

Function
REQ-016 SHALL register every output; all outputs are combinational-free flops.
REQ-017 SHALL resolve simultaneous key pulses with priority key_clr > key_ok > key_next > key_inc; only the winning key acts.
REQ-018 In ENTRY, key_inc SHALL set digit to digit+1, and 9 SHALL wrap to 0.
REQ-019 In ENTRY, key_next SHALL store digit into entry slot pos, clear digit to 0, and advance pos; at pos=3 it SHALL store the digit and leave pos at 3.
REQ-020 In ENTRY, key_ok SHALL store digit into slot pos, latch match = (pos==3 && stored code==PASSWORD), and move to CHECK.
REQ-021 In ENTRY, key_clr SHALL clear the entry buffer, pos and digit to 0.
REQ-022 In ENTRY, TIMEOUT_CYCLES cycles with no key pulse SHALL clear the buffer, pos and digit exactly as key_clr does.
REQ-023 CHECK SHALL last exactly 1 cycle, and key pulses in CHECK SHALL be ignored.
REQ-024 CHECK with match SHALL go to OPEN and clear fail_cnt to 0.
REQ-025 CHECK with mismatch SHALL assert err_pulse for 1 cycle and increment fail_cnt.
REQ-026 After a mismatch, the block SHALL go to LOCKOUT if fail_cnt+1 == MAX_FAIL, otherwise to ENTRY with the buffer cleared.
REQ-027 OPEN SHALL hold unlock=1 for exactly OPEN_CYCLES cycles, then go to ENTRY with unlock=0 and the buffer cleared.
REQ-028 In OPEN, key_clr SHALL relock immediately (next cycle ENTRY, unlock=0), and all other keys SHALL be ignored.
REQ-029 LOCKOUT SHALL hold alarm=1 and ignore all keys for exactly LOCK_CYCLES cycles, then go to ENTRY with alarm=0, fail_cnt=0 and the buffer cleared.
REQ-030 Latency SHALL be: key_ok at edge N -> state=CHECK after N+1 -> unlock=1 (or err_pulse=1) after N+2.
REQ-031 SHALL use one 32-bit timer, cleared on every state change and on any key pulse in ENTRY, and saturating at its terminal count.
REQ-032 fail_cnt SHALL never exceed MAX_FAIL-1 outside CHECK.

Reset
REQ-033 Asserting rst_n low SHALL asynchronously set state=ENTRY, unlock=0, alarm=0, err_pulse=0, pos=0, digit=0, fail_cnt=0, entry buffer=0 and timer=0.
REQ-034 Reset mid-OPEN or mid-LOCKOUT SHALL abort immediately, and the first post-reset edge SHALL start in ENTRY.

Verification (bench uses OPEN_CYCLES=10, LOCK_CYCLES=20, TIMEOUT_CYCLES=15)
REQ-035 Enter 1,2,3,4 via inc/next, then key_ok -> state=1 for one cycle, then unlock=1 for exactly 10 cycles, fail_cnt=0, then state=0.
REQ-036 Enter 1,2,3,5 three times, each followed by key_ok -> err_pulse on each; fail_cnt 1 then 2; 3rd failure gives state=3 and alarm=1 for 20 cycles, with keys ignored; then fail_cnt=0.
REQ-037 key_ok at pos=1 with digits 1,2 -> mismatch and err_pulse=1.
REQ-038 Ten key_inc pulses from digit=0 -> digit=0; key_clr and key_inc in the same cycle -> digit=0 and pos=0.
REQ-039 Enter 1,2, then idle 15 cycles -> pos=0 and digit=0; a correct code then still unlocks.
REQ-040 Assert rst_n low during OPEN -> unlock=0 within the same cycle, and state=0.

Source files
------------

// File: rtl/lock_ctrl.sv
// Keypad combination lock: four BCD digits entered with inc/next, checked on ok,
// with a timed unlock window, a failure counter and a timed lockout.
module lock_ctrl #(
   parameter logic [15:0] PASSWORD       = 16'h1234,
   parameter logic [31:0] OPEN_CYCLES    = 32'd149_999_999,
   parameter logic [31:0] LOCK_CYCLES    = 32'd499_999_999,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd499_999_999,
   parameter logic [1:0]  MAX_FAIL       = 2'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_inc,
   input  logic       key_next,
   input  logic       key_ok,
   input  logic       key_clr,
   output logic       unlock,
   output logic       alarm,
   output logic       err_pulse,
   output logic [1:0] pos,
   output logic [3:0] digit,
   output logic [1:0] fail_cnt,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_CHECK   = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_unlock;
   logic        r_alarm;
   logic        r_err_pulse;
   logic [1:0]  r_pos;
   logic [3:0]  r_digit;
   logic [1:0]  r_fail_cnt;
   logic [15:0] r_code;
   logic        r_match;
   logic [31:0] r_timer;

   logic        w_any_key;
   logic [15:0] w_code;
   logic [3:0]  w_digit_inc;
   logic        w_last_fail;
   logic [1:0]  w_fail_next;

   assign w_any_key   = key_inc | key_next | key_ok | key_clr;
   assign w_digit_inc = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
   assign w_last_fail = ({1'b0, r_fail_cnt} + 3'd1) == {1'b0, MAX_FAIL};
   // The counter stops at MAX_FAIL-1; the failure that reaches MAX_FAIL triggers lockout instead.
   assign w_fail_next = w_last_fail ? r_fail_cnt : r_fail_cnt + 2'd1;

   // Entry buffer with the current digit merged into slot pos (slot 0 is the top nibble).
   always_comb begin
      // NOTE: default assignment first so every path drives w_code and no latch is inferred.
      w_code = r_code;
      case (r_pos)
         2'd0: w_code[15:12] = r_digit;
         2'd1: w_code[11:8]  = r_digit;
         2'd2: w_code[7:4]   = r_digit;
         2'd3: w_code[3:0]   = r_digit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ENTRY;
         r_unlock    <= 1'b0;
         r_alarm     <= 1'b0;
         r_err_pulse <= 1'b0;
         r_pos       <= 2'd0;
         r_digit     <= 4'd0;
         r_fail_cnt  <= 2'd0;
         r_code      <= 16'd0;
         r_match     <= 1'b0;
         r_timer     <= 32'd0;
      end else begin
         // NOTE: non-blocking default makes err_pulse a single-cycle strobe unless CHECK overrides it.
         r_err_pulse <= 1'b0;
         case (r_state)
            ST_ENTRY: begin
               if (w_any_key) begin
                  r_timer <= 32'd0;
               end
               if (key_clr) begin
                  r_code  <= 16'd0;
                  r_pos   <= 2'd0;
                  r_digit <= 4'd0;
               end else if (key_ok) begin
                  r_code  <= w_code;
                  r_match <= (r_pos == 2'd3) && (w_code == PASSWORD);
                  r_state <= ST_CHECK;
               end else if (key_next) begin
                  r_code  <= w_code;
                  r_digit <= 4'd0;
                  if (r_pos != 2'd3) begin
                     r_pos <= r_pos + 2'd1;
                  end
               end else if (key_inc) begin
                  r_digit <= w_digit_inc;
               end else if (r_timer == TIMEOUT_CYCLES - 32'd1) begin
                  r_code  <= 16'd0;
                  r_pos   <= 2'd0;
                  r_digit <= 4'd0;
                  r_timer <= TIMEOUT_CYCLES;
               end else if (r_timer < TIMEOUT_CYCLES) begin
                  r_timer <= r_timer + 32'd1;
               end
            end

            ST_CHECK: begin
               r_timer <= 32'd0;
               r_code  <= 16'd0;
               r_pos   <= 2'd0;
               r_digit <= 4'd0;
               if (r_match) begin
                  r_state    <= ST_OPEN;
                  r_unlock   <= 1'b1;
                  r_fail_cnt <= 2'd0;
               end else begin
                  r_err_pulse <= 1'b1;
                  r_fail_cnt  <= w_fail_next;
                  if (w_last_fail) begin
                     r_state <= ST_LOCKOUT;
                     r_alarm <= 1'b1;
                  end else begin
                     r_state <= ST_ENTRY;
                  end
               end
            end

            ST_OPEN: begin
               if (key_clr || r_timer >= OPEN_CYCLES - 32'd1) begin
                  r_state  <= ST_ENTRY;
                  r_unlock <= 1'b0;
                  r_timer  <= 32'd0;
                  r_code   <= 16'd0;
                  r_pos    <= 2'd0;
                  r_digit  <= 4'd0;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end

            ST_LOCKOUT: begin
               if (r_timer >= LOCK_CYCLES - 32'd1) begin
                  r_state    <= ST_ENTRY;
                  r_alarm    <= 1'b0;
                  r_fail_cnt <= 2'd0;
                  r_timer    <= 32'd0;
                  r_code     <= 16'd0;
                  r_pos      <= 2'd0;
                  r_digit    <= 4'd0;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
         endcase
      end
   end

   assign state     = r_state;
   assign unlock    = r_unlock;
   assign alarm     = r_alarm;
   assign err_pulse = r_err_pulse;
   assign pos       = r_pos;
   assign digit     = r_digit;
   assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random key traffic, every cycle
// compared against a slot/countdown model of the lock's behaviour.
module tb_lock_ctrl;

   localparam logic [15:0] PASSWORD = 16'h1234;
   localparam int OPEN_C  = 10;
   localparam int LOCK_C  = 20;
   localparam int TMO_C   = 15;
   localparam int MAX_F   = 3;
   localparam int S_ENTRY = 0;
   localparam int S_CHECK = 1;
   localparam int S_OPEN  = 2;
   localparam int S_LOCK  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_inc = 1'b0;
   logic       key_next = 1'b0;
   logic       key_ok = 1'b0;
   logic       key_clr = 1'b0;
   logic       unlock;
   logic       alarm;
   logic       err_pulse;
   logic [1:0] pos;
   logic [3:0] digit;
   logic [1:0] fail_cnt;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: entered digits as an array, time spent in OPEN/LOCKOUT as a countdown.
   int m_mode;
   int m_slots[4];
   int m_pos;
   int m_digit;
   int m_fail;
   int m_left;
   int m_idle;
   bit m_err;
   bit m_match;

   lock_ctrl #(
      .PASSWORD      (PASSWORD),
      .OPEN_CYCLES   (32'd10),
      .LOCK_CYCLES   (32'd20),
      .TIMEOUT_CYCLES(32'd15),
      .MAX_FAIL      (2'd3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_inc  (key_inc),
      .key_next (key_next),
      .key_ok   (key_ok),
      .key_clr  (key_clr),
      .unlock   (unlock),
      .alarm    (alarm),
      .err_pulse(err_pulse),
      .pos      (pos),
      .digit    (digit),
      .fail_cnt (fail_cnt),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_clear_entry();
      for (int i = 0; i < 4; i++) m_slots[i] = 0;
      m_pos   = 0;
      m_digit = 0;
   endfunction

   function automatic void model_reset();
      m_clear_entry();
      m_mode  = S_ENTRY;
      m_fail  = 0;
      m_left  = 0;
      m_idle  = 0;
      m_err   = 1'b0;
      m_match = 1'b0;
   endfunction

   function automatic int m_code();
      return (m_slots[0] << 12) | (m_slots[1] << 8) | (m_slots[2] << 4) | m_slots[3];
   endfunction

   // k = {clr, ok, next, inc}; the highest set bit is the key that acts.
   function automatic void model_step(input logic [3:0] k);
      m_err = 1'b0;
      case (m_mode)
         S_ENTRY: begin
            if (k != 4'd0) begin
               m_idle = 0;
               if (k[3]) begin
                  m_clear_entry();
               end else if (k[2]) begin
                  m_slots[m_pos] = m_digit;
                  m_match = (m_pos == 3) && (m_code() == int'(PASSWORD));
                  m_mode  = S_CHECK;
               end else if (k[1]) begin
                  m_slots[m_pos] = m_digit;
                  m_digit = 0;
                  if (m_pos < 3) m_pos++;
               end else begin
                  m_digit = (m_digit + 1) % 10;
               end
            end else begin
               m_idle++;
               if (m_idle == TMO_C) m_clear_entry();
            end
         end
         S_CHECK: begin
            m_clear_entry();
            m_idle = 0;
            if (m_match) begin
               m_mode = S_OPEN;
               m_left = OPEN_C;
               m_fail = 0;
            end else begin
               m_err = 1'b1;
               if (m_fail + 1 == MAX_F) begin
                  m_mode = S_LOCK;
                  m_left = LOCK_C;
               end else begin
                  m_fail++;
                  m_mode = S_ENTRY;
               end
            end
         end
         S_OPEN: begin
            if (k[3]) m_left = 0;
            else m_left--;
            if (m_left == 0) begin
               m_mode = S_ENTRY;
               m_idle = 0;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
               m_mode = S_ENTRY;
               m_fail = 0;
               m_idle = 0;
            end
         end
      endcase
   endfunction

   task automatic compare_all();
      check("state", 32'(state), m_mode);
      check("unlock", 32'(unlock), 32'(m_mode == S_OPEN));
      check("alarm", 32'(alarm), 32'(m_mode == S_LOCK));
      check("err_pulse", 32'(err_pulse), 32'(m_err));
      check("pos", 32'(pos), m_pos);
      check("digit", 32'(digit), m_digit);
      check("fail_cnt", 32'(fail_cnt), m_fail);
   endtask

   // One clock with key vector k = {clr, ok, next, inc} held for exactly that edge.
   task automatic step(input logic [3:0] k);
      @(negedge clk);
      {key_clr, key_ok, key_next, key_inc} = k;
      @(posedge clk);
      model_step(k);
      #1;
      compare_all();
      {key_clr, key_ok, key_next, key_inc} = 4'd0;
   endtask

   // Types the first n digits of code (assumes digit starts at 0), then presses ok.
   task automatic enter_code(input logic [15:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         logic [3:0] d;
         d = 4'(code >> (12 - 4 * i));
         repeat (int'(d)) step(4'b0001);
         if (i < n - 1) step(4'b0010);
      end
      step(4'b0100);
   endtask

   task automatic run_random();
      for (int it = 0; it < 40; it++) begin
         int sel;
         sel = $urandom_range(0, 2);
         if (sel == 0) begin
            repeat ($urandom_range(5, 30)) begin
               logic [3:0] k;
               k = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
               step(k);
            end
         end else if (sel == 1) begin
            enter_code(PASSWORD, 4);
         end else begin
            enter_code({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                       $urandom_range(1, 4));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      compare_all();
      check("rst_state", 32'(state), S_ENTRY);

      // Correct code: one CHECK cycle (keys ignored there), then a 10-cycle unlock.
      enter_code(PASSWORD, 4);
      check("ok_to_check", 32'(state), S_CHECK);
      step(4'b1111);
      check("unlock_rise", 32'(unlock), 1);
      check("open_fail_cnt", 32'(fail_cnt), 0);
      n = 1;
      while (unlock && n < 40) begin
         step(4'b0000);
         if (unlock) n++;
      end
      check("open_len", n, OPEN_C);
      check("after_open_state", 32'(state), S_ENTRY);

      // Three wrong codes: err each time, counter 1 then 2, third one locks out.
      for (int t = 1; t <= 3; t++) begin
         enter_code(16'h1235, 4);
         step(4'b0000);
         check("wrong_err", 32'(err_pulse), 1);
         if (t < 3) check("wrong_fail_cnt", 32'(fail_cnt), t);
      end
      check("lock_state", 32'(state), S_LOCK);
      check("lock_alarm", 32'(alarm), 1);
      n = 1;
      while (alarm && n < 60) begin
         step(4'($urandom));
         if (alarm) n++;
      end
      check("alarm_len", n, LOCK_C);
      check("after_lock_fail_cnt", 32'(fail_cnt), 0);
      check("after_lock_state", 32'(state), S_ENTRY);

      // Short code confirmed at pos=1 is a mismatch.
      enter_code(16'h1200, 2);
      step(4'b0000);
      check("short_err", 32'(err_pulse), 1);

      // Digit wraps 9 -> 0; clr beats a simultaneous inc.
      repeat (10) step(4'b0001);
      check("wrap_digit", 32'(digit), 0);
      step(4'b0001);
      step(4'b0010);
      step(4'b0001);
      check("pre_clr_pos", 32'(pos), 1);
      step(4'b1001);
      check("clr_inc_digit", 32'(digit), 0);
      check("clr_inc_pos", 32'(pos), 0);

      // Inactivity timeout: nothing at 14 idle cycles, cleared at 15.
      step(4'b0001);
      step(4'b0010);
      step(4'b0001);
      step(4'b0001);
      repeat (TMO_C - 1) step(4'b0000);
      check("tmo_hold_pos", 32'(pos), 1);
      check("tmo_hold_digit", 32'(digit), 2);
      step(4'b0000);
      check("tmo_pos", 32'(pos), 0);
      check("tmo_digit", 32'(digit), 0);
      enter_code(PASSWORD, 4);
      step(4'b0000);
      check("tmo_then_unlock", 32'(unlock), 1);
      check("unlock_clears_fail", 32'(fail_cnt), 0);
      step(4'b0000);
      step(4'b0111);
      check("open_ignores_keys", 32'(unlock), 1);
      step(4'b1000);
      check("clr_relock", 32'(unlock), 0);
      check("clr_relock_state", 32'(state), S_ENTRY);

      // Reset in the middle of OPEN drops unlock before the next edge.
      enter_code(PASSWORD, 4);
      repeat (3) step(4'b0000);
      check("pre_rst_unlock", 32'(unlock), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_unlock", 32'(unlock), 0);
      check("rst_open_state", 32'(state), S_ENTRY);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0000);

      run_random();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
